// File: rtl/reg_write_queue.sv
// rtl/reg_write_queue.sv - in-order write-request FIFO feeding the register file write port
// Also flags addresses with a write still queued or in flight, so the read side can spot stale data.
module reg_write_queue #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     stall_in,
    output logic                     wen_out,
    output logic                     waddr_out,
    output logic [DATA_W-1:0]        d_out,
    output logic [$clog2(DEPTH):0]   count_out,
    output logic                     full,
    output logic                     empty,
    input  logic                     query_addr,
    output logic                     pend_hit
);
    localparam int PW = $clog2(DEPTH);

    logic              r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [PW:0]       r_count;
    logic              r_wen;
    logic              r_waddr;
    logic [DATA_W-1:0] r_dout;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_pend_hit;

    // No push-through: a full queue refuses input even when it pops this edge.
    assign w_full  = (r_count == (PW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = !w_empty && !stall_in;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_addr[r_tail] <= in_addr;
            r_mem_data[r_tail] <= in_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_wen   <= 1'b0;
            r_waddr <= 1'b0;
            r_dout  <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head  <= r_head + 1'b1;
                r_waddr <= r_mem_addr[r_head];
                r_dout  <= r_mem_data[r_head];
            end
            r_wen <= w_pop;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Slot i is live when its distance from the head is below the count.
    always_comb begin
        w_pend_hit = r_wen && (r_waddr == query_addr);
        for (int i = 0; i < DEPTH; i++) begin
            if (((PW+1)'(i) < r_count) && (r_mem_addr[r_head + PW'(i)] == query_addr)) begin
                w_pend_hit = 1'b1;
            end
        end
    end

    assign in_ready  = !w_full;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count_out = r_count;
    assign wen_out   = r_wen;
    assign waddr_out = r_waddr;
    assign d_out     = r_dout;
    assign pend_hit  = w_pend_hit;

endmodule

// File: doc/reg_write_queue.md
# reg_write_queue

Write-request buffer that sits directly upstream of the 2-entry, 1-read/1-write-port register file. It accepts write requests (address, data) over a valid/ready handshake and stores them in an in-order FIFO. It drains them one per cycle into the register file's write port (write enable, write address, write data), unless a stall is asserted. It also reports whether a given register address has a write still pending, so read-side logic can detect stale reads.

## Interface

Parameters:
- DATA_W, 16, width of write data; matches register file data width.
- DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  write request present.
- in_ready  out  1  queue can accept; = !full (combinational, independent of same-cycle pop).
- in_addr  in  1  target register index (0/1).
- in_data  in  DATA_W  write data.
- stall_in  in  1  when high, no entry is drained this cycle.
- wen_out  out  1  registered write enable to register file.
- waddr_out  out  1  registered write address.
- d_out  out  DATA_W  registered write data.
- count_out  out  log2(DEPTH)+1  number of entries held in FIFO (excludes output stage).
- full  out  1  count_out == DEPTH.
- empty  out  1  count_out == 0.
- query_addr  in  1  register index being read downstream.
- pend_hit  out  1  combinational: a write to query_addr is queued or on wen_out.

## Operation

- Push: at an edge where in_valid && in_ready, {in_addr, in_data} is written at the tail; tail pointer advances modulo DEPTH.
- Pop: at an edge where !empty && !stall_in, the head entry is loaded into waddr_out/d_out and wen_out<=1. The head pointer advances modulo DEPTH.
- Otherwise wen_out<=0. waddr_out and d_out hold their last values. Downstream must qualify them with wen_out only.
- Strict FIFO order. No merging of writes to the same address; every accepted write reaches the register file exactly once.
- Simultaneous push and pop: both occur and count_out is unchanged. When full, in_ready=0 even if a pop occurs that edge (no push-through).
- Push while empty: the entry is not drained in the same edge; the earliest pop is the next edge.
- pend_hit = OR over valid FIFO entries of (addr==query_addr), OR (wen_out && waddr_out==query_addr).
- Pointers: log2(DEPTH) bits, wrap naturally. count_out is tracked separately (0..DEPTH). Arithmetic never exceeds its range under legal use.
- in_valid while !in_ready: the request is ignored, not stored. The upstream source must hold it.
- Reset (asynchronous, any time, including mid-drain): pointers=0, count_out=0, wen_out=0, waddr_out=0, d_out=0. FIFO storage contents need not be cleared. Pending writes are discarded.
- Reset values of outputs: in_ready=1, full=0, empty=1, count_out=0, wen_out=0, waddr_out=0, d_out=0, pend_hit=0.

## Timing

- Accept-to-write latency, empty queue, no stall: request accepted at edge N. wen_out is high from edge N+1. The register file captures the data at edge N+2.
- Throughput: one push and one pop per cycle sustained.
- stall_in is sampled at the edge. A stall seen at edge N means wen_out=0 after edge N.
- in_ready, full, empty and count_out update one edge after the push/pop that changes them.
- pend_hit is combinational from state and query_addr, with no added latency.

## Test plan

- Reset, then push (addr0, 0x1234) with no stall -> wen_out=1, waddr_out=0, d_out=0x1234 exactly one cycle after acceptance, then wen_out=0; count_out returns to 0.
- stall_in=1, push 4 entries (0xA000..0xA003) -> full=1, in_ready=0; a 5th in_valid is not stored. Release stall -> four consecutive wen_out pulses in order 0xA000..0xA003, then empty=1.
- Full queue with in_valid=1 and no stall -> one pop per cycle; in_ready returns to 1 only after count_out drops to 3; all data stays in order with no loss.
- Steady push+pop every cycle for 20 cycles with addresses alternating 0/1 -> count_out stays constant at 1 or 0 as per start; output sequence equals input sequence.
- Stall and queue (addr1, 0x00FF), then query_addr=1 -> pend_hit=1, and query_addr=0 -> pend_hit=0. After the drain pulse completes -> pend_hit=0.
- Assert reset while 3 entries are queued and wen_out=1 -> wen_out, count_out, d_out go to 0 immediately, without waiting for an edge. After release no stale write is emitted.
